// File: rtl/sync_event_sender_pkg.sv
// Shared types and constants for the toggle-handshake sender front end.
package sync_event_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2,
    WAIT = 2'd3
  } ses_state_t;

  localparam int TIMEOUT_DEFAULT = 64;

  // Largest value a w-bit saturating counter can hold.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_event_sender_sat_updown_cnt.sv
// Saturating up/down counter; drop flags an increment lost at full scale.
module sat_updown_cnt
  import sync_event_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         drop
);

  assign full = (count == W'(cnt_max(W)));
  // A simultaneous dec frees a slot, so only an unmatched inc at full is lost.
  assign drop = inc && !dec && full;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sync_event_sender.sv
// Source-domain event sender feeding the toggle-handshake synchronizer.
// Optional watchdog: define SYNC_EVENT_SENDER_WATCHDOG_EN.
module sync_event_sender
  import sync_event_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             evt_i,
  input  logic             en_i,
  input  logic             ovf_clr_i,
  input  logic             hs_rdy,
  output logic             hs_en,
  output logic [CNT_W-1:0] pending_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             stall_o
);

  ses_state_t state;
  ses_state_t nextState;
  logic       fireNow;
  logic       cntFull;
  logic       cntDrop;
  logic       hsEnQ;
  logic       ovfQ;

  assign fireNow = (state == FIRE);

  sat_updown_cnt #(.W(CNT_W)) uPendCnt (
    .clk   (CLK),
    .rstN  (RST_N),
    .inc   (evt_i),
    .dec   (fireNow),
    .count (pending_o),
    .full  (cntFull),
    .drop  (cntDrop)
  );

  // hs_rdy is deliberately not looked at in HOLD: it is still settling after the toggle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (en_i && hs_rdy && (pending_o != '0)) nextState = FIRE;
      FIRE:    nextState = HOLD;
      HOLD:    nextState = WAIT;
      WAIT:    if (hs_rdy) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // hs_en is a flop loaded with the upcoming FIRE decode, so it is high exactly in FIRE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      hsEnQ <= 1'b0;
    end else begin
      state <= nextState;
      hsEnQ <= (nextState == FIRE);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovfQ <= 1'b0;
    end else if (cntDrop) begin
      ovfQ <= 1'b1;
    end else if (ovf_clr_i) begin
      ovfQ <= 1'b0;
    end
  end

  assign hs_en  = hsEnQ;
  assign ovf_o  = ovfQ;
  assign busy_o = (state != IDLE) || (pending_o != '0);

`ifdef SYNC_EVENT_SENDER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wdCnt;
  logic            stallQ;

  // Counts cycles stuck in WAIT; flags once and keeps waiting, no recovery attempted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdCnt  <= '0;
      stallQ <= 1'b0;
    end else if ((state == WAIT) && !hs_rdy) begin
      if (wdCnt != WD_W'(TIMEOUT)) wdCnt <= wdCnt + 1'b1;
      if (wdCnt == WD_W'(TIMEOUT - 1)) stallQ <= 1'b1;
    end else begin
      wdCnt <= '0;
    end
  end

  assign stall_o = stallQ;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT;
  assign stall_o = 1'b0;
`endif

  logic unusedFull;
  assign unusedFull = cntFull;

endmodule

// File: tb/tb_sync_event_sender.sv
// Directed bench for sync_event_sender paired with a simple synchronizer ready model.
module tb_sync_event_sender;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             evt_i = 1'b0;
  logic             en_i = 1'b0;
  logic             ovf_clr_i = 1'b0;
  logic             hs_rdy;
  logic             hs_en;
  logic [CNT_W-1:0] pending_o;
  logic             busy_o;
  logic             ovf_o;
  logic             stall_o;

  int vectors = 0;
  int miscompares = 0;

  // Synchronizer model: ready drops after each strobe and returns after ret_dly+1 cycles.
  logic rdy_model;
  logic rdy_block = 1'b0;
  int   ret_dly = 1;
  int   rcnt;
  int   pulses = 0;
  int   viol = 0;
  logic rdy_d = 1'b1;

  assign hs_rdy = rdy_model && !rdy_block;

  sync_event_sender #(.CNT_W(CNT_W), .TIMEOUT(64)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .evt_i     (evt_i),
    .en_i      (en_i),
    .ovf_clr_i (ovf_clr_i),
    .hs_rdy    (hs_rdy),
    .hs_en     (hs_en),
    .pending_o (pending_o),
    .busy_o    (busy_o),
    .ovf_o     (ovf_o),
    .stall_o   (stall_o)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_model <= 1'b1;
      rcnt      <= 0;
    end else if (hs_en) begin
      rdy_model <= 1'b0;
      rcnt      <= ret_dly;
    end else if (!rdy_model) begin
      if (rcnt == 0) rdy_model <= 1'b1;
      else rcnt <= rcnt - 1;
    end
  end

  // rdy_d holds hs_rdy from the deciding cycle when a strobe is observed.
  always @(posedge CLK) begin
    if (hs_en) pulses <= pulses + 1;
    if (hs_en && !rdy_d) viol <= viol + 1;
    rdy_d <= hs_rdy;
  end

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while ((busy_o || !hs_rdy) && n < bound) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (busy_o || !hs_rdy) begin
      miscompares++;
      $display("FAIL %s idle timeout: busy=%0b rdy=%0b required busy=0 rdy=1", name, busy_o, hs_rdy);
    end
  endtask

  task automatic wait_fire(input string name, input int bound);
    int n;
    n = 0;
    while (!hs_en && n < bound) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (!hs_en) begin
      miscompares++;
      $display("FAIL %s hs_en timeout: hs_en=0 required 1", name);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    vectors += 5;
    if (hs_en !== 1'b0) begin miscompares++; $display("FAIL rst_hs_en got=%b exp=0", hs_en); end
    if (pending_o !== 4'd0) begin miscompares++; $display("FAIL rst_pending got=%0d exp=0", pending_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%b exp=0", ovf_o); end
    if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%b exp=0", stall_o); end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_single();
    int p0;
    ret_dly = 0;
    en_i = 1'b1;
    p0 = pulses;
    evt_i = 1'b1;
    @(negedge CLK);
    evt_i = 1'b0;
    vectors += 2;
    if (pending_o !== 4'd1) begin miscompares++; $display("FAIL single_pend_n1 got=%0d exp=1", pending_o); end
    if (hs_en !== 1'b0) begin miscompares++; $display("FAIL single_en_n1 got=%b exp=0", hs_en); end
    @(negedge CLK);
    vectors += 2;
    if (hs_en !== 1'b1) begin miscompares++; $display("FAIL single_en_n2 got=%b exp=1", hs_en); end
    if (pending_o !== 4'd1) begin miscompares++; $display("FAIL single_pend_n2 got=%0d exp=1", pending_o); end
    @(negedge CLK);
    vectors += 3;
    if (hs_en !== 1'b0) begin miscompares++; $display("FAIL single_en_n3 got=%b exp=0", hs_en); end
    if (pending_o !== 4'd0) begin miscompares++; $display("FAIL single_pend_n3 got=%0d exp=0", pending_o); end
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_hold got=%b exp=1", busy_o); end
    wait_idle("single", 50);
    vectors++;
    if (pulses - p0 !== 1) begin miscompares++; $display("FAIL single_pulses got=%0d exp=1", pulses - p0); end
  endtask

  task automatic test_burst();
    int p0;
    int peak;
    int n;
    ret_dly = 2;
    en_i = 1'b1;
    p0 = pulses;
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      evt_i = 1'b1;
      @(negedge CLK);
      if (int'(pending_o) > peak) peak = int'(pending_o);
    end
    evt_i = 1'b0;
    n = 0;
    while (busy_o && n < 400) begin
      @(negedge CLK);
      if (int'(pending_o) > peak) peak = int'(pending_o);
      n++;
    end
    wait_idle("burst", 20);
    vectors += 4;
    if (pulses - p0 !== 10) begin miscompares++; $display("FAIL burst_pulses got=%0d exp=10", pulses - p0); end
    if (peak > 10 || peak < 1) begin miscompares++; $display("FAIL burst_peak got=%0d exp=1..10", peak); end
    if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL burst_ovf got=%b exp=0", ovf_o); end
    if (pending_o !== 4'd0) begin miscompares++; $display("FAIL burst_pend got=%0d exp=0", pending_o); end
  endtask

  task automatic test_overflow();
    int p0;
    ret_dly = 3;
    en_i = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      evt_i = 1'b1;
      @(negedge CLK);
    end
    evt_i = 1'b0;
    @(negedge CLK);
    vectors += 3;
    if (pending_o !== 4'd15) begin miscompares++; $display("FAIL ovf_pend got=%0d exp=15", pending_o); end
    if (ovf_o !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
    if (pulses - p0 !== 0) begin miscompares++; $display("FAIL ovf_no_send got=%0d exp=0", pulses - p0); end
    // Drop and clear in the same cycle: the set must win.
    evt_i = 1'b1;
    ovf_clr_i = 1'b1;
    @(negedge CLK);
    evt_i = 1'b0;
    ovf_clr_i = 1'b0;
    vectors++;
    if (ovf_o !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins got=%b exp=1", ovf_o); end
    ovf_clr_i = 1'b1;
    @(negedge CLK);
    ovf_clr_i = 1'b0;
    vectors++;
    if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL ovf_clr got=%b exp=0", ovf_o); end
    // Event coincident with the FIRE cycle at full: count holds, nothing dropped.
    en_i = 1'b1;
    @(negedge CLK);
    wait_fire("full_fire", 10);
    vectors++;
    if (pending_o !== 4'd15) begin miscompares++; $display("FAIL fire_pend_pre got=%0d exp=15", pending_o); end
    evt_i = 1'b1;
    @(negedge CLK);
    evt_i = 1'b0;
    vectors += 2;
    if (pending_o !== 4'd15) begin miscompares++; $display("FAIL fire_pend_hold got=%0d exp=15", pending_o); end
    if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL fire_ovf got=%b exp=0", ovf_o); end
    wait_idle("drain", 400);
    vectors += 2;
    if (pulses - p0 !== 16) begin miscompares++; $display("FAIL drain_pulses got=%0d exp=16", pulses - p0); end
    if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL drain_ovf got=%b exp=0", ovf_o); end
  endtask

  task automatic test_reset_mid();
    int p0;
    ret_dly = 1;
    en_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      evt_i = 1'b1;
      @(negedge CLK);
    end
    evt_i = 1'b0;
    en_i = 1'b1;
    @(negedge CLK);
    wait_fire("mid_fire", 10);
    rdy_block = 1'b1;
    repeat (2) @(negedge CLK);
    vectors += 3;
    if (pending_o !== 4'd5) begin miscompares++; $display("FAIL mid_pend got=%0d exp=5", pending_o); end
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL mid_busy got=%b exp=1", busy_o); end
    if (hs_en !== 1'b0) begin miscompares++; $display("FAIL mid_en got=%b exp=0", hs_en); end
    RST_N = 1'b0;
    #1;
    vectors += 5;
    if (hs_en !== 1'b0) begin miscompares++; $display("FAIL mid_rst_en got=%b exp=0", hs_en); end
    if (pending_o !== 4'd0) begin miscompares++; $display("FAIL mid_rst_pend got=%0d exp=0", pending_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got=%b exp=0", busy_o); end
    if (ovf_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf_o); end
    if (stall_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_stall got=%b exp=0", stall_o); end
    @(negedge CLK);
    rdy_block = 1'b0;
    RST_N = 1'b1;
    p0 = pulses;
    repeat (10) @(negedge CLK);
    vectors += 4;
    if (pulses - p0 !== 0) begin miscompares++; $display("FAIL post_rst_spurious got=%0d exp=0", pulses - p0); end
    if (hs_rdy !== 1'b1) begin miscompares++; $display("FAIL post_rst_rdy got=%b exp=1", hs_rdy); end
    if (pending_o !== 4'd0) begin miscompares++; $display("FAIL post_rst_pend got=%0d exp=0", pending_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_watchdog();
    ret_dly = 0;
    en_i = 1'b1;
    evt_i = 1'b1;
    @(negedge CLK);
    evt_i = 1'b0;
    @(negedge CLK);
    wait_fire("wd_fire", 10);
    rdy_block = 1'b1;
`ifdef SYNC_EVENT_SENDER_WATCHDOG_EN
    for (int i = 1; i <= 66; i++) begin
      @(negedge CLK);
      if (i == 65) begin
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("FAIL wd_early got=%b exp=0", stall_o); end
      end
    end
    vectors += 2;
    if (stall_o !== 1'b1) begin miscompares++; $display("FAIL wd_stall got=%b exp=1", stall_o); end
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL wd_busy got=%b exp=1", busy_o); end
    rdy_block = 1'b0;
    wait_idle("wd_release", 20);
    vectors++;
    if (stall_o !== 1'b1) begin miscompares++; $display("FAIL wd_sticky got=%b exp=1", stall_o); end
`else
    repeat (80) @(negedge CLK);
    vectors += 2;
    if (stall_o !== 1'b0) begin miscompares++; $display("FAIL wd_off_stall got=%b exp=0", stall_o); end
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL wd_off_busy got=%b exp=1", busy_o); end
    rdy_block = 1'b0;
    wait_idle("wd_release", 20);
    vectors++;
    if (stall_o !== 1'b0) begin miscompares++; $display("FAIL wd_off_after got=%b exp=0", stall_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_reset_mid();
    test_watchdog();
    @(negedge CLK);
    vectors++;
    if (viol !== 0) begin miscompares++; $display("FAIL rdy_violation got=%0d exp=0", viol); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
